// File: rtl/ex_stage_unit.sv
// RV32I execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM pipeline register.
// Also keeps saturating counters of branches executed and redirects taken.
module ex_stage_unit #(
   parameter int          PERF_CNT_W = 32,
   parameter logic [31:0] RESET_PC   = 32'h0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  combined_stall,
   input  logic                  ID_EX_enable_out,
   input  logic [31:0]           ID_EX_PC,
   input  logic [31:0]           ID_EX_ReadData1,
   input  logic [31:0]           ID_EX_ReadData2,
   input  logic [31:0]           ID_EX_Immediate,
   input  logic [4:0]            ID_EX_Rs1,
   input  logic [4:0]            ID_EX_Rs2,
   input  logic [4:0]            ID_EX_Rd,
   input  logic [6:0]            ID_EX_Funct7,
   input  logic [2:0]            ID_EX_Funct3,
   input  logic                  ID_EX_ALUSrc,
   input  logic [1:0]            ID_EX_ALUOp,
   input  logic                  ID_EX_Branch,
   input  logic                  ID_EX_Jump,
   input  logic                  ID_EX_JumpReg,
   input  logic                  ID_EX_MemRead,
   input  logic                  ID_EX_MemWrite,
   input  logic                  ID_EX_MemToReg,
   input  logic                  ID_EX_RegWrite,
   input  logic [4:0]            fwd_mem_rd,
   input  logic [4:0]            fwd_wb_rd,
   input  logic                  fwd_mem_regwrite,
   input  logic                  fwd_wb_regwrite,
   input  logic [31:0]           fwd_mem_data,
   input  logic [31:0]           fwd_wb_data,
   output logic                  EX_clear_IF_ID,
   output logic [31:0]           EX_branch_target,
   output logic [31:0]           EX_MEM_PC,
   output logic [31:0]           EX_MEM_ALUResult,
   output logic [31:0]           EX_MEM_WriteData,
   output logic [4:0]            EX_MEM_Rd,
   output logic [2:0]            EX_MEM_Funct3,
   output logic                  EX_MEM_MemRead,
   output logic                  EX_MEM_MemWrite,
   output logic                  EX_MEM_MemToReg,
   output logic                  EX_MEM_RegWrite,
   output logic                  EX_MEM_enable_out,
   output logic                  EX_misaligned_target,
   output logic [PERF_CNT_W-1:0] perf_branch_cnt,
   output logic [PERF_CNT_W-1:0] perf_taken_cnt
);

   // Handshake: ID_EX_enable_out qualifies the incoming bundle; it is consumed on a clock edge
   // where combined_stall is low. EX_MEM_enable_out qualifies the registered bundle toward MEM.
   localparam logic [PERF_CNT_W-1:0] CNT_ONE = PERF_CNT_W'(1);
   localparam logic [PERF_CNT_W-1:0] CNT_MAX = '1;

   logic [31:0] op_a;
   logic [31:0] rs2_val;
   logic [31:0] op_b;
   logic [4:0]  shamt;
   logic [31:0] alu_result;
   logic [31:0] target;
   logic        branch_cond;
   logic        capture;
   logic        redirect;
   logic        unused_funct7;

   assign unused_funct7 = ^{ID_EX_Funct7[6], ID_EX_Funct7[4:0]};

   always_comb begin
      // MEM stage holds the younger result, so it takes priority over WB.
      op_a = ID_EX_ReadData1;
      if (fwd_mem_regwrite && fwd_mem_rd != 5'd0 && fwd_mem_rd == ID_EX_Rs1)
         op_a = fwd_mem_data;
      else if (fwd_wb_regwrite && fwd_wb_rd != 5'd0 && fwd_wb_rd == ID_EX_Rs1)
         op_a = fwd_wb_data;

      rs2_val = ID_EX_ReadData2;
      if (fwd_mem_regwrite && fwd_mem_rd != 5'd0 && fwd_mem_rd == ID_EX_Rs2)
         rs2_val = fwd_mem_data;
      else if (fwd_wb_regwrite && fwd_wb_rd != 5'd0 && fwd_wb_rd == ID_EX_Rs2)
         rs2_val = fwd_wb_data;

      op_b  = ID_EX_ALUSrc ? ID_EX_Immediate : rs2_val;
      shamt = op_b[4:0];

      alu_result = op_a + op_b;
      case (ID_EX_ALUOp)
         2'b00: alu_result = op_a + op_b;
         2'b01: alu_result = op_a - rs2_val;
         2'b10: begin
            case (ID_EX_Funct3)
               3'b000: alu_result = (ID_EX_Funct7[5] && !ID_EX_ALUSrc) ? op_a - op_b : op_a + op_b;
               3'b001: alu_result = op_a << shamt;
               3'b010: alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
               3'b011: alu_result = {31'd0, op_a < op_b};
               3'b100: alu_result = op_a ^ op_b;
               3'b101: alu_result = ID_EX_Funct7[5] ? 32'($signed(op_a) >>> shamt) : op_a >> shamt;
               3'b110: alu_result = op_a | op_b;
               default: alu_result = op_a & op_b;
            endcase
         end
         default: alu_result = ID_EX_Immediate;
      endcase
      // Jumps write the link address regardless of the ALU operation.
      if (ID_EX_Jump)
         alu_result = ID_EX_PC + 32'd4;

      case (ID_EX_Funct3)
         3'b000:  branch_cond = (op_a == rs2_val);
         3'b001:  branch_cond = (op_a != rs2_val);
         3'b100:  branch_cond = ($signed(op_a) < $signed(rs2_val));
         3'b101:  branch_cond = ($signed(op_a) >= $signed(rs2_val));
         3'b110:  branch_cond = (op_a < rs2_val);
         3'b111:  branch_cond = (op_a >= rs2_val);
         default: branch_cond = 1'b0;
      endcase

      target = ID_EX_PC + ID_EX_Immediate;
      if (ID_EX_Jump && ID_EX_JumpReg)
         target = (op_a + ID_EX_Immediate) & ~32'd1;
   end

   assign capture          = ID_EX_enable_out & ~combined_stall;
   assign redirect         = capture & (ID_EX_Jump | (ID_EX_Branch & branch_cond));
   assign EX_clear_IF_ID   = redirect;
   assign EX_branch_target = target;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         EX_MEM_PC            <= RESET_PC;
         EX_MEM_ALUResult     <= 32'd0;
         EX_MEM_WriteData     <= 32'd0;
         EX_MEM_Rd            <= 5'd0;
         EX_MEM_Funct3        <= 3'd0;
         EX_MEM_MemRead       <= 1'b0;
         EX_MEM_MemWrite      <= 1'b0;
         EX_MEM_MemToReg      <= 1'b0;
         EX_MEM_RegWrite      <= 1'b0;
         EX_MEM_enable_out    <= 1'b0;
         EX_misaligned_target <= 1'b0;
         perf_branch_cnt      <= '0;
         perf_taken_cnt       <= '0;
      end else if (capture) begin
         EX_MEM_PC         <= ID_EX_PC;
         EX_MEM_ALUResult  <= alu_result;
         EX_MEM_WriteData  <= rs2_val;
         EX_MEM_Rd         <= ID_EX_Rd;
         EX_MEM_Funct3     <= ID_EX_Funct3;
         EX_MEM_MemRead    <= ID_EX_MemRead;
         EX_MEM_MemWrite   <= ID_EX_MemWrite;
         EX_MEM_MemToReg   <= ID_EX_MemToReg;
         EX_MEM_RegWrite   <= ID_EX_RegWrite;
         EX_MEM_enable_out <= 1'b1;
         if (redirect)
            EX_misaligned_target <= target[1];
         if ((ID_EX_Branch || ID_EX_Jump) && perf_branch_cnt != CNT_MAX)
            perf_branch_cnt <= perf_branch_cnt + CNT_ONE;
         if (redirect && perf_taken_cnt != CNT_MAX)
            perf_taken_cnt <= perf_taken_cnt + CNT_ONE;
      end else if (!combined_stall) begin
         // Bubble: kill the side-effecting controls, leave the data fields as they were.
         EX_MEM_enable_out <= 1'b0;
         EX_MEM_RegWrite   <= 1'b0;
         EX_MEM_MemRead    <= 1'b0;
         EX_MEM_MemWrite   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Randomized scoreboard bench for ex_stage_unit: the driver pushes the expected EX/MEM state each cycle,
// a monitor pops and compares it after every clock edge; redirects are checked combinationally.
module tb_ex_stage_unit;

   localparam int          CW       = 8;
   localparam logic [31:0] RST_PC   = 32'h0000_1000;
   localparam logic [CW-1:0] CMAX   = '1;

   typedef struct packed {
      logic        en;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs1, rs2, rd;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        alusrc;
      logic [1:0]  aluop;
      logic        br, jmp, jr, mr, mw, m2r, rw;
      logic [4:0]  mrd, wrd;
      logic        mrw, wrw;
      logic [31:0] mdata, wdata;
   } bundle_t;

   typedef struct packed {
      logic          en;
      logic [31:0]   pc, alu, wd;
      logic [4:0]    rd;
      logic [2:0]    f3;
      logic          mr, mw, m2r, rw, mis, alu_chk;
      logic [CW-1:0] bcnt, tcnt;
   } exp_t;

   logic clk, reset_n, combined_stall;
   logic ID_EX_enable_out;
   logic [31:0] ID_EX_PC, ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_Immediate;
   logic [4:0]  ID_EX_Rs1, ID_EX_Rs2, ID_EX_Rd;
   logic [6:0]  ID_EX_Funct7;
   logic [2:0]  ID_EX_Funct3;
   logic        ID_EX_ALUSrc;
   logic [1:0]  ID_EX_ALUOp;
   logic        ID_EX_Branch, ID_EX_Jump, ID_EX_JumpReg;
   logic        ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemToReg, ID_EX_RegWrite;
   logic [4:0]  fwd_mem_rd, fwd_wb_rd;
   logic        fwd_mem_regwrite, fwd_wb_regwrite;
   logic [31:0] fwd_mem_data, fwd_wb_data;
   logic        EX_clear_IF_ID;
   logic [31:0] EX_branch_target, EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
   logic [4:0]  EX_MEM_Rd;
   logic [2:0]  EX_MEM_Funct3;
   logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
   logic        EX_MEM_enable_out, EX_misaligned_target;
   logic [CW-1:0] perf_branch_cnt, perf_taken_cnt;

   int   chk_cnt  = 0;
   int   pass_cnt = 0;
   exp_t exp_q[$];
   exp_t m;

   ex_stage_unit #(.PERF_CNT_W(CW), .RESET_PC(RST_PC)) dut (
      .clk(clk), .reset_n(reset_n), .combined_stall(combined_stall),
      .ID_EX_enable_out(ID_EX_enable_out), .ID_EX_PC(ID_EX_PC),
      .ID_EX_ReadData1(ID_EX_ReadData1), .ID_EX_ReadData2(ID_EX_ReadData2),
      .ID_EX_Immediate(ID_EX_Immediate), .ID_EX_Rs1(ID_EX_Rs1), .ID_EX_Rs2(ID_EX_Rs2),
      .ID_EX_Rd(ID_EX_Rd), .ID_EX_Funct7(ID_EX_Funct7), .ID_EX_Funct3(ID_EX_Funct3),
      .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_ALUOp(ID_EX_ALUOp), .ID_EX_Branch(ID_EX_Branch),
      .ID_EX_Jump(ID_EX_Jump), .ID_EX_JumpReg(ID_EX_JumpReg), .ID_EX_MemRead(ID_EX_MemRead),
      .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemToReg(ID_EX_MemToReg),
      .ID_EX_RegWrite(ID_EX_RegWrite), .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
      .fwd_mem_regwrite(fwd_mem_regwrite), .fwd_wb_regwrite(fwd_wb_regwrite),
      .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
      .EX_clear_IF_ID(EX_clear_IF_ID), .EX_branch_target(EX_branch_target),
      .EX_MEM_PC(EX_MEM_PC), .EX_MEM_ALUResult(EX_MEM_ALUResult),
      .EX_MEM_WriteData(EX_MEM_WriteData), .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3),
      .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
      .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
      .EX_MEM_enable_out(EX_MEM_enable_out), .EX_misaligned_target(EX_misaligned_target),
      .perf_branch_cnt(perf_branch_cnt), .perf_taken_cnt(perf_taken_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, chk=%0d", chk_cnt);
      $fatal(1, "timeout");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
   endtask

   // reference model
   function automatic logic [31:0] fwd_val(input logic [4:0] rs, input logic [31:0] rf, input bundle_t b);
      if (b.mrw && b.mrd != 0 && b.mrd == rs) return b.mdata;
      if (b.wrw && b.wrd != 0 && b.wrd == rs) return b.wdata;
      return rf;
   endfunction

   function automatic logic [31:0] model_alu(input bundle_t b);
      logic [31:0] a, y;
      int sh;
      a  = fwd_val(b.rs1, b.rd1, b);
      y  = b.alusrc ? b.imm : fwd_val(b.rs2, b.rd2, b);
      sh = int'(y % 32);
      if (b.jmp) return b.pc + 4;
      if (b.aluop == 2'b11) return b.imm;
      if (b.aluop != 2'b10) return a + y;
      case (b.f3)
         3'd0: return (b.f7[5] && !b.alusrc) ? a - y : a + y;
         3'd1: return a << sh;
         3'd2: return ($signed(a) < $signed(y)) ? 32'd1 : 32'd0;
         3'd3: return (a < y) ? 32'd1 : 32'd0;
         3'd4: return a ^ y;
         3'd5: return b.f7[5] ? 32'($signed(a) >>> sh) : a >> sh;
         3'd6: return a | y;
         default: return a & y;
      endcase
   endfunction

   function automatic logic model_cond(input bundle_t b);
      logic [31:0] a, c;
      a = fwd_val(b.rs1, b.rd1, b);
      c = fwd_val(b.rs2, b.rd2, b);
      case (b.f3)
         3'd0: return a == c;
         3'd1: return a != c;
         3'd4: return $signed(a) < $signed(c);
         3'd5: return $signed(a) >= $signed(c);
         3'd6: return a < c;
         3'd7: return a >= c;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [31:0] model_target(input bundle_t b);
      if (b.jmp && b.jr) return (fwd_val(b.rs1, b.rd1, b) + b.imm) & 32'hFFFF_FFFE;
      return b.pc + b.imm;
   endfunction

   function automatic exp_t reset_state();
      exp_t e;
      e    = '0;
      e.pc = RST_PC;
      return e;
   endfunction

   // driver tasks
   task automatic drive(input bundle_t b);
      ID_EX_enable_out = b.en;     ID_EX_PC = b.pc;
      ID_EX_ReadData1 = b.rd1;     ID_EX_ReadData2 = b.rd2;    ID_EX_Immediate = b.imm;
      ID_EX_Rs1 = b.rs1;           ID_EX_Rs2 = b.rs2;          ID_EX_Rd = b.rd;
      ID_EX_Funct7 = b.f7;         ID_EX_Funct3 = b.f3;        ID_EX_ALUSrc = b.alusrc;
      ID_EX_ALUOp = b.aluop;       ID_EX_Branch = b.br;        ID_EX_Jump = b.jmp;
      ID_EX_JumpReg = b.jr;        ID_EX_MemRead = b.mr;       ID_EX_MemWrite = b.mw;
      ID_EX_MemToReg = b.m2r;      ID_EX_RegWrite = b.rw;
      fwd_mem_rd = b.mrd;          fwd_wb_rd = b.wrd;
      fwd_mem_regwrite = b.mrw;    fwd_wb_regwrite = b.wrw;
      fwd_mem_data = b.mdata;      fwd_wb_data = b.wdata;
   endtask

   task automatic step(input bundle_t b, input logic stall);
      logic taken;
      logic [31:0] tgt;
      @(negedge clk);
      drive(b);
      combined_stall = stall;
      #1;
      taken = b.en && !stall && (b.jmp || (b.br && model_cond(b)));
      tgt   = model_target(b);
      chk("redirect", 32'(EX_clear_IF_ID), 32'(taken));
      if (taken) chk("redirect_target", EX_branch_target, tgt);
      if (!stall) begin
         if (b.en) begin
            m.en = 1'b1; m.pc = b.pc; m.alu = model_alu(b);
            m.wd = fwd_val(b.rs2, b.rd2, b); m.rd = b.rd; m.f3 = b.f3;
            m.mr = b.mr; m.mw = b.mw; m.m2r = b.m2r; m.rw = b.rw;
            m.alu_chk = !(b.aluop == 2'b01 && !b.jmp);
            if (taken) m.mis = tgt[1];
            if ((b.br || b.jmp) && m.bcnt != CMAX) m.bcnt = m.bcnt + 1'b1;
            if (taken && m.tcnt != CMAX) m.tcnt = m.tcnt + 1'b1;
         end else begin
            m.en = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
         end
      end
      exp_q.push_back(m);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #3;
      reset_n = 1'b0;
      drive('0);
      combined_stall = 1'b0;
      exp_q.delete();
      #1;
      chk("rst_redirect", 32'(EX_clear_IF_ID), 32'd0);
      chk("rst_pc", EX_MEM_PC, RST_PC);
      chk("rst_alu", EX_MEM_ALUResult, 32'd0);
      chk("rst_wd", EX_MEM_WriteData, 32'd0);
      chk("rst_ctrl", {18'd0, EX_MEM_Rd, EX_MEM_Funct3, EX_MEM_MemRead, EX_MEM_MemWrite,
                       EX_MEM_MemToReg, EX_MEM_RegWrite, EX_MEM_enable_out, EX_misaligned_target}, 32'd0);
      chk("rst_cnt", {16'd0, perf_branch_cnt, perf_taken_cnt}, 32'd0);
      m = reset_state();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   function automatic bundle_t rand_bundle();
      bundle_t b;
      int kind;
      b = '0;
      b.en = ($urandom_range(0, 7) != 0);
      b.pc = {$urandom_range(0, 32'hFFFF), 2'b00} ; b.imm = $urandom;
      b.rd1 = $urandom; b.rd2 = ($urandom_range(0, 3) == 0) ? b.rd1 : $urandom;
      b.rs1 = 5'($urandom_range(0, 7)); b.rs2 = 5'($urandom_range(0, 7)); b.rd = 5'($urandom);
      b.f7 = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; b.f3 = 3'($urandom);
      b.mr = 1'($urandom); b.mw = 1'($urandom); b.m2r = 1'($urandom); b.rw = 1'($urandom);
      b.mrd = 5'($urandom_range(0, 7)); b.wrd = 5'($urandom_range(0, 7));
      b.mrw = 1'($urandom); b.wrw = 1'($urandom); b.mdata = $urandom; b.wdata = $urandom;
      kind = $urandom_range(0, 6);
      case (kind)
         0: begin b.aluop = 2'b10; b.alusrc = 1'b0; end
         1: begin b.aluop = 2'b10; b.alusrc = 1'b1; end
         2: begin b.aluop = 2'b00; b.alusrc = 1'b1; end
         3: begin b.aluop = 2'b11; b.alusrc = 1'b1; end
         4: begin b.aluop = 2'b01; b.br = 1'b1; end
         5: begin b.jmp = 1'b1; b.aluop = 2'($urandom); end
         default: begin b.jmp = 1'b1; b.jr = 1'b1; b.alusrc = 1'b1; end
      endcase
      return b;
   endfunction

   // scoreboard monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (reset_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("en", 32'(EX_MEM_enable_out), 32'(e.en));
            chk("ctl", {28'd0, EX_MEM_RegWrite, EX_MEM_MemRead, EX_MEM_MemWrite, EX_misaligned_target},
                {28'd0, e.rw, e.mr, e.mw, e.mis});
            chk("cnt", {16'd0, perf_branch_cnt, perf_taken_cnt}, {16'd0, e.bcnt, e.tcnt});
            if (e.en) begin
               chk("pc", EX_MEM_PC, e.pc);
               chk("wdata", EX_MEM_WriteData, e.wd);
               chk("dst", {23'd0, EX_MEM_Rd, EX_MEM_Funct3, EX_MEM_MemToReg},
                   {23'd0, e.rd, e.f3, e.m2r});
               if (e.alu_chk) chk("alu", EX_MEM_ALUResult, e.alu);
            end
         end
      end
   end

   // stimulus
   initial begin
      bundle_t b;
      reset_n = 1'b0;
      combined_stall = 1'b0;
      drive('0);
      m = reset_state();
      do_reset();

      // ADD x3 = x1 + x2
      b = '0; b.en = 1; b.rs1 = 1; b.rs2 = 2; b.rd = 3; b.rd1 = 5; b.rd2 = 7; b.aluop = 2'b10; b.rw = 1;
      step(b, 1'b0);
      @(posedge clk); #2;
      chk("add_result", EX_MEM_ALUResult, 32'd12);
      chk("add_rd_rw_en", {27'd0, EX_MEM_Rd, EX_MEM_RegWrite, EX_MEM_enable_out}, {27'd0, 5'd3, 1'b1, 1'b1});

      // ADDI with both MEM and WB matching rs1: MEM wins, funct7[5] ignored with an immediate
      b = '0; b.en = 1; b.rs1 = 4; b.rd = 6; b.imm = 1; b.alusrc = 1; b.aluop = 2'b10; b.f7 = 7'h20;
      b.mrd = 4; b.mrw = 1; b.mdata = 32'h10; b.wrd = 4; b.wrw = 1; b.wdata = 32'h20; b.rw = 1;
      step(b, 1'b0);
      @(posedge clk); #2;
      chk("fwd_priority", EX_MEM_ALUResult, 32'h11);

      // BEQ taken, then the same instruction under stall
      b = '0; b.en = 1; b.pc = 32'h100; b.imm = 32'h40; b.rs1 = 1; b.rs2 = 2; b.rd1 = 9; b.rd2 = 9;
      b.aluop = 2'b01; b.br = 1;
      step(b, 1'b0);
      chk("beq_taken", {31'd0, EX_clear_IF_ID}, 32'd1);
      chk("beq_target", EX_branch_target, 32'h140);
      step(b, 1'b1);
      chk("beq_stalled", {31'd0, EX_clear_IF_ID}, 32'd0);

      // JALR held for three stall cycles, then captured
      b = '0; b.en = 1; b.pc = 32'h80; b.rs1 = 5; b.rd1 = 32'h203; b.rd = 1; b.jmp = 1; b.jr = 1;
      b.alusrc = 1; b.rw = 1;
      for (int i = 0; i < 3; i++) begin
         step(b, 1'b1);
         @(posedge clk); #2;
         chk("stall_hold_pc", EX_MEM_PC, 32'h100);
      end
      step(b, 1'b0);
      chk("jalr_target", EX_branch_target, 32'h202);
      @(posedge clk); #2;
      chk("jalr_link", EX_MEM_ALUResult, 32'h84);
      chk("jalr_misaligned", {31'd0, EX_misaligned_target}, 32'd1);

      // randomized traffic
      for (int i = 0; i < 400; i++)
         step(rand_bundle(), ($urandom_range(0, 4) == 0));

      // drive the taken counter into saturation
      b = '0; b.en = 1; b.jmp = 1; b.pc = 32'h200; b.imm = 32'h10; b.rw = 1; b.rd = 1;
      for (int i = 0; i < 300; i++) step(b, 1'b0);
      @(posedge clk); #2;
      chk("taken_saturated", 32'(perf_taken_cnt), 32'(CMAX));
      chk("branch_saturated", 32'(perf_branch_cnt), 32'(CMAX));

      // reset while a jump is being presented
      step(b, 1'b0);
      do_reset();
      for (int i = 0; i < 20; i++)
         step(rand_bundle(), ($urandom_range(0, 4) == 0));

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
